// File: rtl/digit_serial_subtractor.sv
// Digit-serial subtractor: D = A - B - bin, DIGIT bits per cycle, LSB digit first.
// Define SUB_OVERFLOW_EN to add the signed-overflow output ovf.
module digit_serial_subtractor #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] D,
    output logic             prev_bout,
    output logic             bout
`ifdef SUB_OVERFLOW_EN
    ,
    output logic             ovf
`endif
);

    localparam int NUM_DIGITS = WIDTH / DIGIT;
    localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    generate
        if (DIGIT < 1 || WIDTH < 2 || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
            $fatal(1, "digit_serial_subtractor: illegal WIDTH/DIGIT combination");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               carry_q, carry_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   d_q, d_d;
    logic               prev_bout_q, prev_bout_d;
    logic               bout_q, bout_d;

    logic [DIGIT-1:0]   a_dig, b_dig;
    logic [DIGIT:0]     sum;
    logic [WIDTH-1:0]   a_shift, b_shift;
    logic               last_digit;

    assign a_dig = a_q[DIGIT-1:0];
    assign b_dig = b_q[DIGIT-1:0];
    assign sum   = {1'b0, a_dig} + {1'b0, ~b_dig} + {{DIGIT{1'b0}}, carry_q};
    assign last_digit = (idx_q == IDX_W'(NUM_DIGITS - 1));

    // The minuend register doubles as the result accumulator: each consumed
    // digit is replaced by its difference digit entering from the top.
    generate
        if (DIGIT == WIDTH) begin : g_single
            assign a_shift = sum[DIGIT-1:0];
            assign b_shift = '0;
        end else begin : g_multi
            assign a_shift = {sum[DIGIT-1:0], a_q[WIDTH-1:DIGIT]};
            assign b_shift = {{DIGIT{1'b0}}, b_q[WIDTH-1:DIGIT]};
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            idx_q       <= '0;
            d_q         <= '0;
            prev_bout_q <= 1'b0;
            bout_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            carry_q     <= carry_d;
            idx_q       <= idx_d;
            d_q         <= d_d;
            prev_bout_q <= prev_bout_d;
            bout_q      <= bout_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        carry_d     = carry_q;
        idx_d       = idx_q;
        d_d         = d_q;
        prev_bout_d = prev_bout_q;
        bout_d      = bout_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = A;
                    b_d     = B;
                    carry_d = ~bin;
                    idx_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                a_d     = a_shift;
                b_d     = b_shift;
                carry_d = sum[DIGIT];
                idx_d   = idx_q + IDX_W'(1);
                if (last_digit) begin
                    d_d         = a_shift;
                    bout_d      = ~sum[DIGIT];
                    // Borrow into the MSB recovered from the MSB sum bit: s ^ a ^ b.
                    prev_bout_d = sum[DIGIT-1] ^ a_dig[DIGIT-1] ^ b_dig[DIGIT-1];
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == DONE);
    assign D         = d_q;
    assign prev_bout = prev_bout_q;
    assign bout      = bout_q;

`ifdef SUB_OVERFLOW_EN
    logic ovf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (state_q == BUSY && last_digit) begin
            ovf_q <= prev_bout_d ^ bout_d;
        end
    end

    assign ovf = ovf_q & out_valid;
`endif

endmodule

// File: doc/digit_serial_subtractor.md
DIGIT_SERIAL_SUBTRACTOR -- requirements
Module: digit_serial_subtractor

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand and result width in bits.
REQ-002 SHALL have parameter DIGIT, default 8: bits processed per cycle.
REQ-003 SHALL define NUM_DIGITS = WIDTH/DIGIT and stop elaboration with $fatal if WIDTH%DIGIT != 0, DIGIT < 1, or WIDTH < 2.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port in_valid  input  1  operands and bin are valid.
REQ-007 SHALL have port in_ready  output  1  block accepts operands.
REQ-008 SHALL have port A  input  WIDTH  minuend.
REQ-009 SHALL have port B  input  WIDTH  subtrahend.
REQ-010 SHALL have port bin  input  1  borrow-in.
REQ-011 SHALL have port out_valid  output  1  result valid.
REQ-012 SHALL have port out_ready  input  1  consumer accepts result.
REQ-013 SHALL have port D  output  WIDTH  difference.
REQ-014 SHALL have port prev_bout  output  1  borrow out of bit WIDTH-2 into bit WIDTH-1.
REQ-015 SHALL have port bout  output  1  borrow out of bit WIDTH-1.

Function
REQ-016 SHALL compute D = (A - B - bin) mod 2^WIDTH, with bout = 1 iff unsigned A < B + bin.
REQ-017 SHALL implement each digit as A_digit + ~B_digit + carry, with initial carry = ~bin; borrow = ~carry.
REQ-018 SHALL process digits LSB first, one digit per cycle, with the carry held in a register between digits.
REQ-019 SHALL implement the FSM IDLE -> BUSY -> DONE -> IDLE.
REQ-020 SHALL drive in_ready = 1 only in IDLE and only while rst is low.
REQ-021 SHALL capture A, B and bin on an edge where in_valid & in_ready, clear the digit index, and go to BUSY.
REQ-022 SHALL, in BUSY, process digit[idx] on each edge; on the edge with idx = NUM_DIGITS-1 it SHALL go to DONE.
REQ-023 SHALL make out_valid visible after edge t0+NUM_DIGITS, where t0 is the accept edge.
REQ-024 SHALL drive out_valid = 1 only in DONE, and SHALL hold D, prev_bout and bout stable while out_valid & !out_ready.
REQ-025 SHALL, in DONE, go to IDLE on the edge where out_ready = 1.
REQ-026 SHALL not accept a new operation in that same edge; throughput is one operation per NUM_DIGITS+2 cycles.
REQ-027 SHALL ignore in_valid in BUSY and DONE; inputs are not sampled and state is unaffected.
REQ-028 SHALL hold D, prev_bout and bout at the last result until the next completion.
REQ-029 SHALL, for DIGIT = WIDTH, have NUM_DIGITS = 1 and a latency of 1 edge in BUSY.

Reset
REQ-030 SHALL, while rst = 1, set state = IDLE, D = 0, prev_bout = 0, bout = 0, out_valid = 0 and in_ready = 0; any ovf output SHALL also be 0.
REQ-031 SHALL, on rst mid-BUSY or in DONE, discard the operation; no out_valid follows.
REQ-032 SHALL allow the first accept on the first edge after rst deasserts.

Configuration
REQ-033 SHALL, with macro SUB_OVERFLOW_EN defined, add output port ovf (1 bit) = prev_bout ^ bout, registered with and qualified by out_valid.
REQ-034 SHALL, without SUB_OVERFLOW_EN, have no ovf port and no overflow logic; all other behaviour is identical.

Verification (WIDTH=32, DIGIT=8)
REQ-035 Test: A=0x00000005, B=0x00000003, bin=0 -> D=0x00000002, bout=0, prev_bout=0; out_valid exactly after edge t0+4.
REQ-036 Test: A=0x00000000, B=0x00000001, bin=0 -> D=0xFFFFFFFF, bout=1, prev_bout=1, ovf=0.
REQ-037 Test: A=0x80000000, B=0x00000001, bin=0 -> D=0x7FFFFFFF, bout=0, prev_bout=1, ovf=1.
REQ-038 Test: A=0x00000010, B=0x0000000F, bin=1 -> D=0x00000000, bout=0, prev_bout=0.
REQ-039 Test: out_ready=0 for 10 cycles in DONE, with in_valid pulsed meanwhile -> outputs stable, in_ready=0; no extra result after out_ready=1.
REQ-040 Test: rst pulse on the 2nd BUSY cycle -> out_valid=0, D=0, in_ready=1 after release; next op A=7, B=2 -> D=5.
